maxpool_flatten: RTL

// Downstream of the conv/ReLU stage. After L0 kernel-0/kernel-1 maps (64x64, 20-bit) are in memory,

---
 rtl/maxpool_flatten.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 signed max-pool over two L0 kernel maps, writing each pooled pixel to its
// L1 bank and to the kernel-interleaved L2 flatten bank over the shared memory bus.
module maxpool_flatten #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  localparam int unsigned PW = IMG_W / 2;
  localparam int unsigned CW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_WR2  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              kern_q, kern_d;
  logic [DATA_W-1:0] max_q, max_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              crd_q, crd_d;
  logic              cwr_q, cwr_d;
  logic [2:0]        csel_q, csel_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;

  logic              last_px;
  logic              sample_gt;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Next-state logic; bus outputs are then derived from the next state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    kern_d     = kern_q;
    max_d      = max_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    csel_d     = 3'b000;
    caddr_rd_d = '0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;

    last_px   = (row_q == CW'(PW - 1)) && (col_q == CW'(PW - 1)) && kern_q;
    sample_gt = $signed(cdata_rd) > $signed(max_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          cnt_d   = 2'd0;
        end
      end
      S_RD: begin
        // Sample n lands during read cycle n+1; the first one seeds the max register.
        if (cnt_q == 2'd1) begin
          max_d = cdata_rd;
        end else if ((cnt_q != 2'd0) && sample_gt) begin
          max_d = cdata_rd;
        end
        if (cnt_q == 2'd3) begin
          state_d = S_LAST;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_LAST: begin
        if (sample_gt) begin
          max_d = cdata_rd;
        end
        state_d = S_WR1;
      end
      S_WR1: begin
        state_d = S_WR2;
      end
      S_WR2: begin
        cnt_d = 2'd0;
        if (last_px) begin
          state_d = S_DONE;
          row_d   = '0;
          col_d   = '0;
          kern_d  = 1'b0;
        end else begin
          state_d = S_RD;
          kern_d  = ~kern_q;
          if (kern_q) begin
            col_d = col_q + CW'(1);
            if (col_q == CW'(PW - 1)) begin
              row_d = row_q + CW'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pix_addr = ADDR_W'(row_d) * ADDR_W'(PW) + ADDR_W'(col_d);
    rd_addr  = ADDR_W'(row_d) * ADDR_W'(2 * IMG_W) + ADDR_W'(col_d) * ADDR_W'(2)
             + (cnt_d[1] ? ADDR_W'(IMG_W) : '0) + ADDR_W'(cnt_d[0]);

    busy_d = (state_d == S_RD) || (state_d == S_LAST) || (state_d == S_WR1) || (state_d == S_WR2);
    done_d = (state_d == S_DONE);

    case (state_d)
      S_RD: begin
        crd_d      = 1'b1;
        csel_d     = kern_d ? SEL_L0K1 : SEL_L0K0;
        caddr_rd_d = rd_addr;
      end
      S_WR1: begin
        cwr_d      = 1'b1;
        csel_d     = kern_d ? SEL_L1K1 : SEL_L1K0;
        caddr_wr_d = pix_addr;
        cdata_wr_d = max_d;
      end
      S_WR2: begin
        cwr_d      = 1'b1;
        csel_d     = SEL_L2;
        caddr_wr_d = {pix_addr[ADDR_W-2:0], kern_d};
        cdata_wr_d = max_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      row_q      <= '0;
      col_q      <= '0;
      kern_q     <= 1'b0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= 3'b000;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      kern_q     <= kern_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign cwr      = cwr_q;
  assign csel     = csel_q;
  assign caddr_rd = caddr_rd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;

endmodule
